// File: rtl/updown_counter_gen2.sv
// updown_counter_gen2: parametrised up/down counter with run-time limit, wrap/saturate, load, prescaler and terminal-count pulse
module updown_counter_gen2 #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ud,
    input  logic             sat,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] lim,
    input  logic [PRE_W-1:0] div,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [PRE_W-1:0] PONE = PRE_W'(1);
    logic [PRE_W-1:0] pcnt, pcnt_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             step, at_edge, tc_nxt;
    assign step    = en && (pcnt >= div);
    assign at_edge = ud ? (cnt >= lim) : (cnt == '0);
    // next-state: load wins, then prescaled step with boundary handling, else hold
    always_comb begin
        pcnt_nxt = ld ? '0 : !en ? pcnt : step ? '0 : pcnt + PONE;
        cnt_nxt  = ld ? din : !step ? cnt :
                   at_edge ? (ud == sat ? lim : '0) :
                   ud ? cnt + ONE : cnt - ONE;
        tc_nxt   = !ld && step && at_edge;
    end
    // state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            cnt  <= '0;
            tc   <= 1'b0;
        end else begin
            pcnt <= pcnt_nxt;
            cnt  <= cnt_nxt;
            tc   <= tc_nxt;
        end
    end
endmodule

// File: doc/updown_counter_gen2.md
# updown_counter_gen2

Parametrised up/down binary counter: the next-generation counter core for the tile's user wrapper, replacing the fixed 4-bit counter. It adds:
- configurable width;
- a run-time modulo limit;
- wrap or saturate mode;
- synchronous parallel load;
- an enable prescaler;
- a registered terminal-count pulse.

The wrapper maps its inputs from the dedicated input pins and drives the dedicated outputs from `cnt` and `tc`.

## Interface
- `WIDTH`, default 8: counter width in bits, legal range 2–16.
- `PRE_W`, default 4: prescaler width in bits, legal range 1–8.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `en`  in  1  count enable; gates the prescaler.
- `ud`  in  1  direction: 1 = up, 0 = down.
- `sat`  in  1  boundary mode: 1 = saturate, 0 = wrap.
- `ld`  in  1  synchronous load strobe.
- `din`  in  WIDTH  load value.
- `lim`  in  WIDTH  modulo limit; count range is 0..`lim`.
- `div`  in  PRE_W  prescale divisor; one step per `div`+1 enabled cycles.
- `cnt`  out  WIDTH  current count, registered.
- `tc`  out  1  terminal-count pulse, registered.

## Operation
- State: `cnt` (WIDTH), internal prescale counter `pcnt` (PRE_W), `tc`.
- Reset (`rst_n`=0, asynchronous): `cnt`=0, `pcnt`=0, `tc`=0. Outputs hold these values until the first rising edge after deassertion.
- Step strobe (combinational, internal): `step` = `en` & (`pcnt` >= `div`).
- Prescaler, per edge, in priority order:
  - `ld`=1: `pcnt`←0.
  - `en`=0: `pcnt` holds.
  - `step`=1: `pcnt`←0.
  - otherwise: `pcnt`←`pcnt`+1.
- Counter, per edge, in priority order:
  1. `ld`=1: `cnt`←`din`, `tc`←0. `din` > `lim` is accepted as-is.
  2. `step`=1, `ud`=1:
     - if `cnt` >= `lim`: wrap mode `cnt`←0; saturate mode `cnt`←`lim`; `tc`←1 in both modes.
     - else `cnt`←`cnt`+1, `tc`←0.
  3. `step`=1, `ud`=0:
     - if `cnt`==0: wrap mode `cnt`←`lim`; saturate mode `cnt`←0; `tc`←1 in both modes.
     - else `cnt`←`cnt`−1, `tc`←0.
  4. No step: `cnt` holds, `tc`←0.
- `tc` is high for exactly one cycle per boundary step. Saturate mode with `en` held and `div`=0 keeps `tc` high continuously.
- `lim`=0: every step is a boundary step. `cnt` stays 0 in wrap mode (up or down).
- All arithmetic is modulo 2^WIDTH. Comparisons are unsigned. The `+1` and `−1` paths never overflow because boundary checks come first.
- `div`, `lim`, `ud` and `sat` may change on any cycle and take effect on the same edge's evaluation.
- `div` lowered below the current `pcnt`: the `>=` compare issues a step on the next enabled cycle. No wait for a `pcnt` wrap.
- `div`=0: one step per enabled cycle, identical to the legacy counter behaviour.

## Timing
- `cnt` and `tc` change only on the rising `clk` edge, or asynchronously on reset assertion.
- Load latency: `din` is visible on `cnt` 1 cycle after `ld` is sampled high.
- Step latency: `cnt` updates on the edge where `step` is true. Latency from first `en`=1 with `pcnt`=0 is `div`+1 edges.
- `tc` is coincident with the `cnt` value produced by the boundary step: same edge, registered.
- Reset deasserted asynchronously mid-count: first post-reset step occurs `div`+1 enabled edges later.
- No combinational path from any input to any output.

## Test plan
- Reset: WIDTH=8, hold `en`=1, assert `rst_n`=0 mid-count (`cnt`=0x37) between edges -> `cnt`=0, `tc`=0 immediately; after release, `cnt`=1 on the first edge (`div`=0).
- Wrap up: `lim`=9, `div`=0, `ud`=1, `sat`=0, `en`=1 from 0 -> `cnt` 0..9, then 0. `tc`=1 only in the cycle `cnt` returns to 0; pattern repeats every 10 cycles.
- Saturate down: load `din`=3, then `ud`=0, `sat`=1, `en`=1 -> `cnt` 2, 1, 0, 0, 0. `tc` low through 2, 1, 0; high from the first held-0 cycle onward.
- Prescaler: `div`=3, `en`=1 -> `cnt` increments every 4th edge. Drop `en` for 2 cycles mid-period -> phase preserved, next step delayed exactly 2 cycles. Change `div` 7→1 with `pcnt`=5 -> step on next enabled edge.
- Load priority: `ld`=1, `din`=0xF0, with `en`=1, `step` due and `lim`=0x20 -> `cnt`=0xF0, `tc`=0, `pcnt`=0. Next up step (`sat`=0) -> `cnt`=0, `tc`=1.
- Degenerate limit: `lim`=0, wrap mode, `en`=1, both directions -> `cnt` stays 0, `tc` high every step cycle.
